// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: size codes, FSM states and request checks.
package mem_resp_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRmwWait,
        StWr,
        StResp,
        StErr
    } state_e;

    function automatic logic rd_lat_legal(int unsigned lat);
        return (lat >= 1) && (lat <= 3);
    endfunction

    // Size 11 is never legal; halves need an even address, words a 4-byte aligned one.
    function automatic logic req_legal(logic [1:0] size, logic [1:0] off);
        logic ok;
        case (size)
            SZ_WORD: ok = (off == 2'b00);
            SZ_HALF: ok = !off[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_responder_byte_lane_merge.sv
// Little-endian lane extraction (loads) and lane merge (read-modify-write stores).
module byte_lane_merge
    import mem_resp_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;

    assign shamt = {off_i, 3'b000};

    always_comb begin
        extract_o = word_i;
        lane_mask = '1;
        case (size_i)
            SZ_HALF: begin
                extract_o = {16'h0000, word_i[{off_i[1], 4'b0000} +: 16]};
                lane_mask = 32'h0000_ffff << shamt;
            end
            SZ_BYTE: begin
                extract_o = {24'h000000, word_i[shamt +: 8]};
                lane_mask = 32'h0000_00ff << shamt;
            end
            default: ;
        endcase
        merge_o = (word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: sized loads/stores onto a single-port word RAM,
// sub-word stores via read-modify-write, one-cycle response pulse.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    if (!rd_lat_legal(RD_LAT)) begin : gen_bad_rd_lat
        $error("mem_responder: RD_LAT must be in 1..3");
    end

    localparam logic [1:0] LastCnt = 2'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] lane_rdata;
    logic [31:0] merged;

    byte_lane_merge u_lane (
        .word_i    (ram_rdata),
        .wdata_i   (wdata_q),
        .size_i    (size_q),
        .off_i     (off_q),
        .extract_o (lane_rdata),
        .merge_o   (merged)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    size_d     = req_size;
                    off_d      = req_addr[1:0];
                    wdata_d    = req_wdata;
                    ram_addr_d = {req_addr[31:2], 2'b00};
                    cnt_d      = '0;
                    if (!req_legal(req_size, req_addr[1:0])) begin
                        state_d = StErr;
                        rdata_d = '0;
                    end else if (!req_write) begin
                        state_d = StRdWait;
                    end else if (req_size == SZ_WORD) begin
                        state_d     = StWr;
                        ram_wdata_d = req_wdata;
                    end else begin
                        state_d = StRmwWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == LastCnt) begin
                    rdata_d = lane_rdata;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StRmwWait: begin
                if (cnt_q == LastCnt) begin
                    ram_wdata_d = merged;
                    state_d     = StWr;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StWr: begin
                // Stores respond with zero data.
                rdata_d = '0;
                state_d = StResp;
            end
            StResp, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            size_q      <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign ram_we    = (state_q == StWr);
    assign rsp_valid = (state_q == StResp) || (state_q == StErr);
    assign rsp_err   = (state_q == StErr);
    assign rsp_rdata = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
